// File: rtl/fetch_block.sv
// Instruction fetch stage: fetch PC, credit-limited imem requests, prefetch FIFO toward decode.
// Define FETCH_PERF_COUNTERS_EN to add saturating fetched/discarded/stall-cycle counters.
module fetch_block #(
  parameter int unsigned     DEPTH       = 2,
  parameter int unsigned     INSTR_WIDTH = 16,
  parameter int unsigned     WORD        = 32,
  parameter logic [WORD-1:0] RESET_PC    = '0,
  parameter logic [WORD-1:0] PC_OFFSET   = WORD'(4)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_pipeline_i,
  input  logic                   flush_pipeline_i,
  input  logic [WORD-1:0]        branch_target_i,
  output logic                   imem_req_o,
  output logic [WORD-1:0]        imem_addr_o,
  input  logic                   imem_ready_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic                   is_valid_o,
  output logic [WORD-1:0]        program_counter_o
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [WORD-1:0]        perf_fetched_o,
  output logic [WORD-1:0]        perf_discarded_o,
  output logic [WORD-1:0]        perf_stall_cycles_o
`endif
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [WORD-1:0]        fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]          count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WORD-1:0]        addr_mem_q  [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q, instr_d, head_instr;
  logic [WORD-1:0]        pc_q, pc_d, head_addr;
  logic                   valid_q, valid_d;
  logic                   accept, push, pop, drop, head_is_new;
  logic [SW-1:0]          inflight;

  // FIFO slots already claimed by buffered entries plus requests still in flight
  assign inflight    = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_o  = !reset_i && !flush_pipeline_i && (inflight < SW'(DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign accept      = imem_req_o && imem_ready_i;
  assign drop        = imem_rvalid_i && (discard_q != '0);
  assign push        = imem_rvalid_i && (discard_q == '0) && !flush_pipeline_i;
  assign pop         = valid_q && !stall_pipeline_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (flush_pipeline_i) begin
      // every request accepted before this edge will be dropped on return
      fetch_pc_d = branch_target_i & ~WORD'(1);
      resp_pc_d  = branch_target_i & ~WORD'(1);
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      outst_d    = outst_q - CW'(imem_rvalid_i);
      discard_d  = outst_q - CW'(imem_rvalid_i);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + WORD'(2);
      outst_d = outst_q + CW'(accept) - CW'(imem_rvalid_i);
      if (drop) discard_d = discard_q - CW'(1);
      if (push) begin
        wr_d      = wr_q + PW'(1);
        resp_pc_d = resp_pc_q + WORD'(2);
      end
      if (pop) rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    // output registers preload the next head; a response landing at the head bypasses storage
    head_is_new = push && (wr_q == rd_d);
    head_instr  = head_is_new ? imem_rdata_i : instr_mem_q[rd_d];
    head_addr   = head_is_new ? resp_pc_q : addr_mem_q[rd_d];
    valid_d     = (count_d != '0);
    instr_d     = instr_q;
    pc_d        = pc_q;
    if (valid_d) begin
      instr_d = head_instr;
      pc_d    = head_addr + PC_OFFSET;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      instr_q    <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_q] <= imem_rdata_i;
      addr_mem_q[wr_q]  <= resp_pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && push) assert (count_q < CW'(DEPTH));
  end

  assign instruction_o     = instr_q;
  assign is_valid_o        = valid_q;
  assign program_counter_o = pc_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [WORD-1:0] perf_fetched_q, perf_discarded_q, perf_stall_q, disc_inc;

  function automatic logic [WORD-1:0] sat_add(input logic [WORD-1:0] a, input logic [WORD-1:0] b);
    logic [WORD:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WORD] ? '1 : s[WORD-1:0];
  endfunction

  // a flush drops every buffered entry plus whatever response arrives alongside it
  assign disc_inc = flush_pipeline_i ? (WORD'(count_q) + WORD'(imem_rvalid_i)) : WORD'(drop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
      perf_stall_q     <= '0;
    end else begin
      perf_fetched_q   <= sat_add(perf_fetched_q, WORD'(push));
      perf_discarded_q <= sat_add(perf_discarded_q, disc_inc);
      perf_stall_q     <= sat_add(perf_stall_q, WORD'(valid_q && stall_pipeline_i));
    end
  end

  assign perf_fetched_o      = perf_fetched_q;
  assign perf_discarded_o    = perf_discarded_q;
  assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_block.sv
// Self-checking bench for fetch_block: latency-configurable imem model plus an in-order scoreboard.
module tb_fetch_block;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned IW    = 16;
  localparam int unsigned WORD  = 32;

  logic            clk = 1'b0;
  logic            reset_i = 1'b1, stall_pipeline_i = 1'b0, flush_pipeline_i = 1'b0;
  logic [WORD-1:0] branch_target_i = '0;
  logic            imem_req_o, imem_ready_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [WORD-1:0] imem_addr_o;
  logic [IW-1:0]   imem_rdata_i = '0;
  logic [IW-1:0]   instruction_o;
  logic            is_valid_o;
  logic [WORD-1:0] program_counter_o;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [WORD-1:0] perf_fetched_o, perf_discarded_o, perf_stall_cycles_o;
`endif

  always #5 clk = ~clk;

  fetch_block #(.DEPTH(DEPTH), .INSTR_WIDTH(IW), .WORD(WORD),
                .RESET_PC('0), .PC_OFFSET(32'd4)) dut (
    .clk_i(clk), .reset_i(reset_i), .stall_pipeline_i(stall_pipeline_i),
    .flush_pipeline_i(flush_pipeline_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instruction_o(instruction_o), .is_valid_o(is_valid_o),
    .program_counter_o(program_counter_o)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_fetched_o(perf_fetched_o), .perf_discarded_o(perf_discarded_o),
    .perf_stall_cycles_o(perf_stall_cycles_o)
`endif
  );

  typedef struct { logic [WORD-1:0] addr; int due; } pend_t;
  typedef struct { logic [IW-1:0] instr; logic [WORD-1:0] pc; } exp_t;
  typedef struct {
    int          lat;
    logic [3:0]  ready_pat;
    logic [7:0]  stall_pat;
    int          n_cycles;
    int          exp_first;
  } vec_t;

  pend_t           pend[$];
  exp_t            sb[$];
  vec_t            vecs[5];
  int              checks = 0, failures = 0;
  int              cyc = 0, lat = 1, n_since = 0, first_valid = 0;
  logic            prev_flush = 1'b0;
  logic [WORD-1:0] exp_pc = '0, last_pc = '0;
  logic [IW-1:0]   last_instr = '0;

  function automatic logic [IW-1:0] hash(input logic [WORD-1:0] a);
    return IW'(a[15:0] ^ (a[15:0] >> 4) ^ 16'hC3A5);
  endfunction

  task automatic chk(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe at negedge, advance the imem model after the posedge.
  task automatic cycle();
    pend_t p;
    exp_t  e;
    @(negedge clk);
    n_since++;
    if (!reset_i) begin
      if (prev_flush) chk("valid_after_flush", WORD'(is_valid_o), 0);
      if (flush_pipeline_i) chk("flush_no_req", WORD'(imem_req_o), 0);
      if (is_valid_o) begin
        if (first_valid == 0) first_valid = n_since;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid: got pc 0x%0h expected no output", program_counter_o);
        end else begin
          chk("instr", WORD'(instruction_o), WORD'(sb[0].instr));
          chk("pc", program_counter_o, sb[0].pc);
          last_instr = sb[0].instr;
          last_pc    = sb[0].pc;
          if (!stall_pipeline_i) void'(sb.pop_front());
        end
      end else begin
        chk("hold_instr", WORD'(instruction_o), WORD'(last_instr));
        chk("hold_pc", program_counter_o, last_pc);
      end
      if (imem_rvalid_i) void'(pend.pop_front());
      if (imem_req_o && imem_ready_i) begin
        chk("req_addr", imem_addr_o, exp_pc);
        p.addr = imem_addr_o;
        p.due  = cyc + lat;
        pend.push_back(p);
        e.instr = hash(exp_pc);
        e.pc    = exp_pc + 32'd4;
        sb.push_back(e);
        exp_pc += 32'd2;
        chk("outstanding_le_depth", WORD'(pend.size() <= DEPTH), 1);
      end
      if (flush_pipeline_i) begin
        sb.delete();
        exp_pc = branch_target_i & ~32'd1;
      end
    end
    prev_flush = flush_pipeline_i && !reset_i;
    @(posedge clk);
    cyc++;
    #1;
    if (reset_i) pend.delete();
    imem_rvalid_i = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rdata_i  = imem_rvalid_i ? hash(pend[0].addr) : '0;
  endtask

  task automatic clear_model();
    sb.delete();
    exp_pc = '0; last_instr = '0; last_pc = '0;
    first_valid = 0; n_since = 0; prev_flush = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; flush_pipeline_i = 1'b0; stall_pipeline_i = 1'b0;
    imem_ready_i = 1'b0; branch_target_i = '0;
    cycle(); cycle();
    chk("rst_valid", WORD'(is_valid_o), 0);
    chk("rst_instr", WORD'(instruction_o), 0);
    chk("rst_pc", program_counter_o, 0);
    chk("rst_req", WORD'(imem_req_o), 0);
    clear_model();
    reset_i = 1'b0;
  endtask

  task automatic drain();
    imem_ready_i = 1'b0; stall_pipeline_i = 1'b0; flush_pipeline_i = 1'b0;
    for (int k = 0; k < 30 && (sb.size() != 0 || pend.size() != 0); k++) cycle();
    cycle();
    chk("drained", WORD'(sb.size()), 0);
  endtask

  task automatic run_row(input vec_t v);
    lat = v.lat;
    do_reset();
    for (int n = 0; n < v.n_cycles; n++) begin
      imem_ready_i     = v.ready_pat[n % 4];
      stall_pipeline_i = v.stall_pat[n % 8];
      cycle();
    end
    chk("first_valid_cycle", WORD'(first_valid), WORD'(v.exp_first));
    drain();
  endtask

  initial begin
    vecs[0] = '{1, 4'b1111, 8'h00,        16, 3};
    vecs[1] = '{2, 4'b1111, 8'h00,        16, 4};
    vecs[2] = '{3, 4'b1001, 8'h00,        20, 5};
    vecs[3] = '{1, 4'b1111, 8'b0110_1100, 20, 3};
    vecs[4] = '{2, 4'b0110, 8'b1011_0010, 24, 5};
    for (int i = 0; i < 5; i++) run_row(vecs[i]);

    // long stall: output frozen, requests stop once the credits are used up
    lat = 1;
    do_reset();
    imem_ready_i = 1'b1;
    for (int n = 0; n < 6; n++) cycle();
    stall_pipeline_i = 1'b1;
    for (int n = 0; n < 5; n++) cycle();
    chk("stall_req_drop", WORD'(imem_req_o), 0);
    stall_pipeline_i = 1'b0;
    for (int n = 0; n < 6; n++) cycle();
    drain();

    // flush with two requests in flight
    lat = 3;
    do_reset();
    imem_ready_i = 1'b1;
    cycle(); cycle();
    chk("two_outstanding", WORD'(pend.size()), 2);
    flush_pipeline_i = 1'b1; branch_target_i = 32'h101;
    cycle();
    flush_pipeline_i = 1'b0;
    chk("redirect_addr", imem_addr_o, 32'h100);
    for (int k = 0; k < 20 && !is_valid_o; k++) cycle();
    chk("flush_first_pc", program_counter_o, 32'h104);
    for (int n = 0; n < 6; n++) cycle();
    drain();

    // flush, response and stall all in the same cycle
    lat = 1;
    do_reset();
    imem_ready_i = 1'b1; stall_pipeline_i = 1'b1;
    for (int k = 0; k < 10 && !(imem_rvalid_i && is_valid_o); k++) cycle();
    chk("flush_rvalid_setup", WORD'(imem_rvalid_i && is_valid_o), 1);
    flush_pipeline_i = 1'b1; branch_target_i = 32'h40;
    cycle();
    flush_pipeline_i = 1'b0; stall_pipeline_i = 1'b0;
    chk("flush_stall_valid", WORD'(is_valid_o), 0);
    for (int n = 0; n < 10; n++) cycle();
    drain();

    // reset with exactly one request outstanding
    lat = 3;
    do_reset();
    imem_ready_i = 1'b1;
    for (int n = 0; n < 6; n++) cycle();
    imem_ready_i = 1'b0;
    for (int k = 0; k < 15 && (pend.size() != 0 || is_valid_o); k++) cycle();
    imem_ready_i = 1'b1;
    cycle();
    imem_ready_i = 1'b0;
    chk("one_outstanding", WORD'(pend.size()), 1);
    reset_i = 1'b1;
    cycle();
    chk("midrst_valid", WORD'(is_valid_o), 0);
    chk("midrst_instr", WORD'(instruction_o), 0);
    chk("midrst_pc", program_counter_o, 0);
    chk("midrst_req", WORD'(imem_req_o), 0);
    clear_model();
    reset_i = 1'b0;
    imem_ready_i = 1'b1;
    chk("restart_addr", imem_addr_o, 0);
    for (int n = 0; n < 10; n++) cycle();
    chk("restart_first_valid", WORD'(first_valid), 5);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_block.md
Name: fetch_block

Overview:
- Instruction fetch stage, directly upstream of the decode stage.
- Holds the fetch PC and issues in-order requests to instruction memory over a req/ready request channel and an rvalid response channel.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode as instruction/is_valid/program_counter.
- Obeys the decode stall signal. Redirects on the WB-stage flush, discarding all buffered and in-flight fetches.

Parameters:
- DEPTH, 2, prefetch FIFO entries. Also the maximum number of outstanding imem requests. Power of two, ≥2.
- INSTR_WIDTH, 16, instruction width in bits (Thumb encoding).
- RESET_PC, 0, fetch address after reset.
- PC_OFFSET, 4, added to the instruction address to form program_counter_o (architectural PC read value).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- stall_pipeline_i  in  1  stall_pipeline_sig from decode; 1 = hold current output
- flush_pipeline_i  in  1  flush_pipeline_sig from WB; 1 = redirect to branch_target_i
- branch_target_i  in  WORD  redirect address; bit 0 ignored
- imem_req_o  out  1  request valid
- imem_addr_o  out  WORD  request address (halfword aligned)
- imem_ready_i  in  1  imem accepts the request this cycle
- imem_rvalid_i  in  1  response valid (in order, ≥1 cycle after acceptance)
- imem_rdata_i  in  INSTR_WIDTH  response instruction
- instruction_o  out  INSTR_WIDTH  instruction to decode
- is_valid_o  out  1  instruction_o/program_counter_o valid
- program_counter_o  out  WORD  instruction address + PC_OFFSET

Behaviour:
- Reset (reset_i=1 at posedge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - Outputs: imem_req_o=0, is_valid_o=0, instruction_o=0, program_counter_o=0.
  - Reset mid-transaction: responses arriving later are ignored only if discard covers them. Reset therefore also sets discard=0, and the imem side is required to be reset in the same cycle.
- Issue:
  - imem_req_o = !reset_i & !flush_pipeline_i & (count + outstanding < DEPTH).
  - imem_addr_o = fetch_pc.
  - Request is accepted when imem_req_o & imem_ready_i. On acceptance: fetch_pc += 2 and outstanding++.
  - The request may be held across cycles; the address stays stable while not accepted.
- Response:
  - On imem_rvalid_i: outstanding--.
  - If discard>0: discard-- and the data is dropped.
  - Otherwise push {imem_rdata_i, address} into the FIFO. The address is tracked by a per-entry PC queue or a resp_pc counter incremented by 2 per kept response.
  - Credit accounting guarantees the FIFO is never full on a kept response. Push when full is an assertion failure.
- Output:
  - is_valid_o = (count≠0).
  - instruction_o = head instruction; program_counter_o = head address + PC_OFFSET.
  - All three come from registered storage; no combinational path from imem_rdata_i.
  - When count=0, instruction_o and program_counter_o hold their last value (0 after reset).
- Pop: when is_valid_o & !stall_pipeline_i. Push and pop in the same cycle are allowed and leave count unchanged.
- Flush (highest priority after reset):
  - FIFO cleared.
  - fetch_pc = {branch_target_i[WORD-1:1],1'b0}.
  - discard = outstanding − (imem_rvalid_i ? 1 : 0) + (discard adjustment if the current response was already a discard). Net effect: every request accepted before the flush edge is dropped.
  - imem_req_o=0 in the flush cycle. is_valid_o=0 in the cycle after the flush.
  - First new request is issued the cycle after the flush.
  - Flush with stall: flush wins; the stalled instruction is dropped.
- Latency: after reset or flush, first instruction reaches is_valid_o = 1 cycle (issue) + imem latency + 1 cycle (FIFO write).
- Wrap-around: fetch_pc wraps modulo 2^WORD. FIFO pointers wrap modulo DEPTH.
- Counters are sized $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined: adds output ports perf_fetched_o (WORD), perf_discarded_o (WORD) and perf_stall_cycles_o (WORD), all reset to 0 and saturating at all-ones.
  - perf_fetched_o counts FIFO pushes.
  - perf_discarded_o counts dropped responses plus FIFO entries cleared by flush.
  - perf_stall_cycles_o counts cycles with is_valid_o & stall_pipeline_i.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, imem ready always and 1-cycle latency → addresses 0,2,4,... are issued. First is_valid_o=1 in cycle 3 with program_counter_o=4. Then one instruction per cycle, with program_counter_o incrementing by 2.
- stall_pipeline_i=1 for 5 cycles with DEPTH=2 → instruction_o and program_counter_o stay stable. imem_req_o drops once count+outstanding=2. After release, instructions resume in order with none lost or duplicated.
- flush_pipeline_i=1 with branch_target_i=0x101 while 2 requests are outstanding → both responses are dropped and the next imem_addr_o is 0x100. First valid output has program_counter_o=0x104.
- flush_pipeline_i and imem_rvalid_i in the same cycle, with stall_pipeline_i=1 → response dropped, FIFO empty, is_valid_o=0 the next cycle.
- imem_ready_i toggling 1,0,0,1 with 3-cycle latency → imem_addr_o is held while not ready, outputs stay in order, and outstanding never exceeds DEPTH.
- reset_i asserted mid-stream with 1 request outstanding → outputs return to their reset values on the next cycle, and fetch restarts at RESET_PC.
